// File: rtl/seq_adder_pkg.sv
// Shared types and elaboration helpers for the sequential slice adder.
// Parameter-derived sizes are computed here so every user agrees on them.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-pass configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    function automatic bit width_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/seq_adder_ctrl_add_slice.sv
// Purely combinational SLICE-bit ripple adder shared across all passes.
module add_slice #(
    parameter int SLICE = 32
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] s_o,
    output logic             cout_o
);

    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};

endmodule

// File: rtl/seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one SLICE-bit adder,
// least-significant slice first, with valid/ready on both sides.
module seq_adder_ctrl
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDXW   = calc_idx_w(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if (!width_ok(WIDTH, SLICE)) begin : g_bad_params
            $error("seq_adder_ctrl: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [SLICE-1:0]  a_sl [NSLICE];
    logic [SLICE-1:0]  b_sl [NSLICE];
    logic [SLICE-1:0]  slice_a, slice_b, slice_s;
    logic              slice_cout;
    logic              run_pass;

    assign run_pass = (state_q == RUN);

    // Only the slice addressed by idx is rewritten; the rest hold their contents.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_sl[gi] = op_a_q[gi*SLICE +: SLICE];
            assign b_sl[gi] = op_b_q[gi*SLICE +: SLICE];
            assign sum_d[gi*SLICE +: SLICE] =
                (run_pass && (idx_q == IDXW'(gi))) ? slice_s : sum_q[gi*SLICE +: SLICE];
        end
    endgenerate

    assign slice_a = a_sl[idx_q];
    assign slice_b = b_sl[idx_q];

    add_slice #(
        .SLICE(SLICE)
    ) u_add_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1, so B is stored pre-inverted.
                    op_a_d  = a;
                    op_b_d  = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                              (slice_s[SLICE-1] != op_a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
